// File: rtl/ucsbece154b_prefetch.sv
// ucsbece154b_prefetch: in-order instruction prefetcher that tags responses with their PC
// and hands them to a downstream FIFO through a skid buffer, with redirect flushing.
module ucsbece154b_prefetch #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ready_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [63:0] fifo_data_o,
  output logic        fifo_push_o,
  input  logic        fifo_full_i
);
  localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW:0] MAXV = (CW+1)'(MAX_OUTSTANDING);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d, cnt_q, cnt_d;
  logic [PW-1:0] pq_head_q, pq_head_d, pq_tail_q, pq_tail_d;
  logic [PW-1:0] sk_head_q, sk_head_d, sk_tail_q, sk_tail_d;
  logic [31:0] pcq_q [MAX_OUTSTANDING];
  logic [31:0] pcq_d [MAX_OUTSTANDING];
  logic [63:0] skid_q [MAX_OUTSTANDING];
  logic [63:0] skid_d [MAX_OUTSTANDING];
  logic accept, skid_wr;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction
  assign mem_req_o   = state_q == RUN && !redirect_i && ({1'b0, out_q} + {1'b0, cnt_q} < MAXV);
  assign mem_addr_o  = pc_q;
  assign fifo_data_o = cnt_q != 0 ? skid_q[sk_head_q] : '0;
  always_comb begin
    accept      = mem_req_o && mem_ready_i;
    skid_wr     = mem_rvalid_i && !redirect_i && drop_q == 0;
    fifo_push_o = cnt_q != 0 && !fifo_full_i && !redirect_i;
    pcq_d       = pcq_q;
    skid_d      = skid_q;
    if (accept) pcq_d[pq_tail_q] = pc_q;
    if (skid_wr) skid_d[sk_tail_q] = {pcq_q[pq_head_q], mem_rdata_i};
    // the PC queue drains on every response, dropped or not, so tags stay aligned
    pq_tail_d = accept ? inc(pq_tail_q) : pq_tail_q;
    pq_head_d = mem_rvalid_i ? inc(pq_head_q) : pq_head_q;
    out_d     = out_q + CW'(accept) - CW'(mem_rvalid_i);
    pc_d      = redirect_i ? redirect_pc_i & ~32'd3 : accept ? pc_q + 32'd4 : pc_q;
    sk_head_d = redirect_i ? '0 : fifo_push_o ? inc(sk_head_q) : sk_head_q;
    sk_tail_d = redirect_i ? '0 : skid_wr ? inc(sk_tail_q) : sk_tail_q;
    cnt_d     = redirect_i ? '0 : cnt_q + CW'(skid_wr) - CW'(fifo_push_o);
    drop_d    = redirect_i ? out_q - CW'(mem_rvalid_i)
              : (mem_rvalid_i && drop_q != 0) ? drop_q - 1'b1 : drop_q;
    state_d   = state_q == IDLE ? RUN
              : redirect_i ? (drop_d != 0 ? FLUSH : RUN)
              : (state_q == FLUSH && drop_d == 0) ? RUN : state_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      out_q     <= '0;
      drop_q    <= '0;
      cnt_q     <= '0;
      pq_head_q <= '0;
      pq_tail_q <= '0;
      sk_head_q <= '0;
      sk_tail_q <= '0;
      pcq_q     <= '{default: '0};
      skid_q    <= '{default: '0};
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
      cnt_q     <= cnt_d;
      pq_head_q <= pq_head_d;
      pq_tail_q <= pq_tail_d;
      sk_head_q <= sk_head_d;
      sk_tail_q <= sk_tail_d;
      pcq_q     <= pcq_d;
      skid_q    <= skid_d;
    end
  end
  a_rsp_needs_request: assert property (@(posedge clk_i) disable iff (rst_i) mem_rvalid_i |-> out_q != 0)
    else $error("response received with nothing outstanding");
endmodule
